// File: rtl/sub32_iter.sv
// sub32_iter: iterative 32-bit adder/subtractor.
//   Computes A+B (sub=0) or A-B (sub=1) CHUNK bits per clock, least
//   significant slice first. An operation takes N = 32/CHUNK RUN cycles.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request; accepted in IDLE or DONE, ignored in RUN
//   sub      in   1 = subtract, captured with start
//   A, B     in   32-bit operands, captured with start
//   busy     out  operation in progress (state RUN)
//   done     out  one-cycle pulse, results newly updated (state DONE)
//   S        out  result, held until the next completion
//   carry    out  carry out of bit 31 (for subtraction 1 = no borrow)
//   overflow out  signed overflow
//   zero     out  S == 0
//
// Handshake: start is a request sampled on the rising edge. It is taken
// whenever the block is in IDLE or DONE (DONE doubles as the accept cycle
// for back-to-back work). done and busy are never high together; results
// are valid during the done cycle and stay stable afterwards.

module sub32_iter #(
  parameter int CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] S,
  output logic        carry,
  output logic        overflow,
  output logic        zero
);

  localparam int N  = 32 / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d;       // operand a, shifted right one slice per cycle
  logic [31:0]   b_q, b_d;       // operand b' = B ^ {32{sub}}, shifted likewise
  logic          c_q, c_d;       // ripple carry between slices
  logic [31:0]   acc_q, acc_d;   // result slices enter from the top
  logic [31:0]   s_q, s_d;
  logic          carry_q, carry_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;
  logic [CHUNK:0] sum;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    s_d     = s_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    sum     = '0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B ^ {32{sub}};
          c_d     = sub;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_q};
        // After N shifts the accumulator holds slice 0 in the low bits.
        acc_d = (acc_q >> CHUNK) | (32'(sum[CHUNK-1:0]) << (32 - CHUNK));
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        c_d   = sum[CHUNK];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // On the last slice the low bits of a_q/b_q are the original
          // top slice, so bit CHUNK-1 is bit 31 of a and b'.
          state_d = DONE;
          cnt_d   = '0;
          s_d     = acc_d;
          carry_d = sum[CHUNK];
          ovf_d   = (a_q[CHUNK-1] == b_q[CHUNK-1]) && (sum[CHUNK-1] != a_q[CHUNK-1]);
          zero_d  = (acc_d == 32'd0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      acc_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign S        = s_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_sub32_iter.sv
// Testbench for sub32_iter: four instances (CHUNK = 1, 4, 8, 32) share the
// operand inputs and reset; each has its own start so single-instance
// handshake sequences can be run without disturbing the others.

module tb_sub32_iter;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  start_v;
  logic        sub_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [3:0]  busy_v, done_v, carry_v, ovf_v, zero_v;
  logic [31:0] s_v [4];

  int n_checks;
  int n_fail;
  exp_t exp_q[$];
  exp_t tbl [9];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int CH = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 32;
    sub32_iter #(.CHUNK(CH)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_v[g]),
      .sub      (sub_i),
      .A        (a_i),
      .B        (b_i),
      .busy     (busy_v[g]),
      .done     (done_v[g]),
      .S        (s_v[g]),
      .carry    (carry_v[g]),
      .overflow (ovf_v[g]),
      .zero     (zero_v[g])
    );
  end

  function automatic int nk(input int k);
    return (k == 0) ? 32 : (k == 1) ? 8 : (k == 2) ? 4 : 1;
  endfunction

  // Golden model built from plain integer arithmetic.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    exp_t e;
    logic [32:0] w;
    longint full;
    e.a = a; e.b = b; e.sub = sub;
    w   = {1'b0, a} + {1'b0, b};
    e.s = sub ? (a - b) : (a + b);
    e.c = sub ? (a >= b) : w[32];
    full = sub ? (longint'($signed(a)) - longint'($signed(b)))
               : (longint'($signed(a)) + longint'($signed(b)));
    e.v = (full != longint'($signed(e.s)));
    e.z = (e.s == 32'd0);
    return e;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (chunk inst %0d): got %h required %h", name, k, act, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int k, input exp_t e);
    chk({tag, "_S"}, k, s_v[k], e.s);
    chk({tag, "_carry"}, k, 32'(carry_v[k]), 32'(e.c));
    chk({tag, "_overflow"}, k, 32'(ovf_v[k]), 32'(e.v));
    chk({tag, "_zero"}, k, 32'(zero_v[k]), 32'(e.z));
  endtask

  task automatic chk_reset_vals(input string tag, input int k);
    chk({tag, "_busy"}, k, 32'(busy_v[k]), 32'd0);
    chk({tag, "_done"}, k, 32'(done_v[k]), 32'd0);
    chk({tag, "_S"}, k, s_v[k], 32'd0);
    chk({tag, "_flags"}, k, {29'd0, carry_v[k], ovf_v[k], zero_v[k]}, 32'd0);
  endtask

  // driver: accept one operation on the instances in mask, then score each
  task automatic run_op(input logic [3:0] mask, input exp_t e);
    exp_t got;
    logic [3:0] seen;
    exp_q.push_back(e);
    @(negedge clk);
    a_i = e.a; b_i = e.b; sub_i = e.sub; start_v = mask;
    @(posedge clk);
    @(negedge clk);
    start_v = 4'd0;
    for (int k = 0; k < 4; k++)
      if (mask[k]) chk("busy_after_accept", k, 32'(busy_v[k]), 32'd1);
    seen = 4'd0;
    got  = exp_q[0];
    for (int cyc = 1; cyc <= 40 && (seen & mask) != mask; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (mask[k] && !seen[k] && done_v[k]) begin
          seen[k] = 1'b1;
          chk("latency", k, 32'(cyc), 32'(nk(k)));
          chk("busy_with_done", k, 32'(busy_v[k]), 32'd0);
          chk_res("op", k, got);
          if (got.sub)
            chk("slt", k, 32'(s_v[k][31] ^ ovf_v[k]), 32'($signed(got.a) < $signed(got.b)));
        end
      end
    end
    void'(exp_q.pop_front());
    for (int k = 0; k < 4; k++)
      if (mask[k] && !seen[k]) chk("done_timeout", k, 32'd0, 32'd1);
  endtask

  // Back-to-back: start held in DONE is taken with no bubble.
  task automatic hold_seq(input int k);
    logic found;
    @(negedge clk);
    a_i = 32'd5; b_i = 32'd7; sub_i = 1'b1; start_v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[k] = 1'b0;
    found = 1'b0;
    for (int cyc = 1; cyc <= 40 && !found; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_v[k]) found = 1'b1;
    end
    chk("hold_first_done", k, 32'(found), 32'd1);
    chk("hold_first_S", k, s_v[k], 32'hFFFF_FFFE);
    chk("hold_busy_in_done", k, 32'(busy_v[k]), 32'd0);
    a_i = 32'd10; b_i = 32'd3; sub_i = 1'b1; start_v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[k] = 1'b0;
    chk("hold_busy_rise", k, 32'(busy_v[k]), 32'd1);
    chk("hold_no_done", k, 32'(done_v[k]), 32'd0);
    chk("hold_S_held", k, s_v[k], 32'hFFFF_FFFE);
    for (int cyc = 1; cyc <= nk(k); cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc < nk(k)) begin
        chk("hold_S_held_run", k, s_v[k], 32'hFFFF_FFFE);
        chk("hold_done_early", k, 32'(done_v[k]), 32'd0);
      end else begin
        chk("hold_second_done", k, 32'(done_v[k]), 32'd1);
        chk("hold_second_S", k, s_v[k], 32'd7);
      end
    end
  endtask

  // start pulsed during RUN with different operands must be ignored.
  task automatic ignore_seq(input int k);
    int found_cyc;
    exp_t e;
    e = '{32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    a_i = e.a; b_i = e.b; sub_i = e.sub; start_v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_i = 32'd1; b_i = 32'd1; sub_i = 1'b0;   // start stays high into RUN
    @(posedge clk);
    @(negedge clk);
    start_v[k] = 1'b0;
    found_cyc = done_v[k] ? 1 : 0;
    for (int cyc = 2; cyc <= 40 && found_cyc == 0; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_v[k]) found_cyc = cyc;
    end
    chk("ignore_latency", k, 32'(found_cyc), 32'(nk(k)));
    chk_res("ignore", k, e);
    @(posedge clk);
    @(negedge clk);
    chk("ignore_no_rerun_busy", k, 32'(busy_v[k]), 32'd0);
    chk("ignore_no_second_done", k, 32'(done_v[k]), 32'd0);
  endtask

  // Reset two cycles into an operation aborts it.
  task automatic reset_seq(input int k);
    logic [3:0] any_done;
    @(negedge clk);
    a_i = 32'h1234_5678; b_i = 32'h1111_1111; sub_i = 1'b0; start_v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[k] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midop_reset", k);
    @(negedge clk);
    rst_n = 1'b1;
    any_done = 4'd0;
    repeat (nk(k) + 3) begin
      @(posedge clk);
      @(negedge clk);
      any_done = any_done | done_v;
    end
    chk("midop_no_done", k, 32'(any_done), 32'd0);
    run_op(4'(1 << k), model(32'h0000_FFFF, 32'd1, 1'b0));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start_v  = 4'd0;
    sub_i    = 1'b0;
    a_i      = '0;
    b_i      = '0;

    //              a             b             sub   s             c     v     z
    tbl[0] = '{32'd5,        32'd7,        1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'h8000_0000, 32'd1,        1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{32'hFFFF_FFFF, 32'd1,        1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{32'd10,       32'd3,        1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{32'd0,        32'd0,        1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{32'h7FFF_FFFF, 32'd1,        1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{32'd0,        32'd1,        1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{32'd7,        32'd7,        1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) chk_reset_vals("reset_state", k);
    rst_n = 1'b1;

    // reset asserted mid-cycle with start high
    @(negedge clk);
    a_i = 32'hDEAD_BEEF; b_i = 32'h0BAD_F00D; start_v = 4'hF;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 for (int k = 0; k < 4; k++) chk_reset_vals("async_reset", k);
    @(negedge clk);
    start_v = 4'd0;
    rst_n   = 1'b1;
    begin
      logic [3:0] any_done;
      any_done = 4'd0;
      repeat (10) begin
        @(posedge clk);
        @(negedge clk);
        any_done = any_done | done_v;
      end
      chk("post_reset_no_done", 0, 32'(any_done), 32'd0);
    end

    for (int i = 0; i < 9; i++) run_op(4'hF, tbl[i]);

    for (int k = 0; k < 4; k++) begin
      hold_seq(k);
      ignore_seq(k);
      reset_seq(k);
    end

    for (int i = 0; i < 500; i++) begin
      logic [31:0] ra, rb;
      logic [31:0] corner [4];
      corner[0] = 32'h0; corner[1] = 32'hFFFF_FFFF;
      corner[2] = 32'h8000_0000; corner[3] = 32'h7FFF_FFFF;
      ra = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      run_op(4'hF, model(ra, rb, 1'($urandom_range(0, 1))));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
